decimal_keypad_debouncer: RTL and testbench



---
 rtl/keypad_pkg.sv | 24 ++
 rtl/decimal_keypad_debouncer_if.sv | 39 +++
 rtl/sync_2ff.sv | 34 +++
 rtl/decimal_keypad_debouncer.sv | 134 +++++++++++++
 tb/tb_decimal_keypad_debouncer.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the decimal keypad front-end: key count,
// FSM state encoding and a one-hot test.
package keypad_pkg;

    localparam int NUM_KEYS = 10;

    // IDLE     : no key seen on the synchronised lines
    // DB_PRESS : candidate pattern being checked for stability
    // PRESSED  : press accepted or rejected, waiting for full release
    // DB_REL   : all-zero seen, checking release for stability
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DB_PRESS = 2'd1,
        PRESSED  = 2'd2,
        DB_REL   = 2'd3
    } state_e;

    // True iff exactly one bit of v is set. Clearing the lowest set bit
    // of a non-zero word leaves zero only when one bit was set.
    function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
        return (v != '0) && ((v & (v - NUM_KEYS'(1))) == '0);
    endfunction

endpackage

// File: rtl/decimal_keypad_debouncer_if.sv
// Keypad bus: raw key lines in, debounced one-hot key and strobes out.
// dbg_state mirrors the debouncer FSM state for observation.
//
// Handshake: there is no back-pressure. key_valid is a one-cycle strobe
// that qualifies a new value on decimal_out; the consumer must take it on
// that cycle or lose the event (decimal_out itself is held until the next
// accepted press). multi_err is a one-cycle strobe and is never high in the
// same cycle as key_valid.
interface decimal_keypad_debouncer_if;
    import keypad_pkg::*;

    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] decimal_out;
    logic                key_valid;
    logic                key_held;
    logic                multi_err;
    state_e              dbg_state;

    // Keypad side / test driver: supplies raw lines, observes results.
    modport master (
        output key_raw,
        input  decimal_out,
        input  key_valid,
        input  key_held,
        input  multi_err,
        input  dbg_state
    );

    // Debouncer side.
    modport slave (
        input  key_raw,
        output decimal_out,
        output key_valid,
        output key_held,
        output multi_err,
        output dbg_state
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a bus of independent asynchronous bits.
// Each bit is synchronised on its own; no coherence across bits is implied.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_d, meta_q;
    logic [WIDTH-1:0] sync_d, sync_q;

    // Next values: shift the raw input one stage down the chain.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchroniser flops, cleared immediately on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/decimal_keypad_debouncer.sv
// Decimal keypad front-end: synchronises ten raw key lines, debounces
// press and release, and accepts one key at a time. A stable one-hot
// pattern loads decimal_out and strobes key_valid; a stable multi-key
// pattern strobes multi_err instead. A full release is required between
// presses, so roll-over to another key is ignored.
module decimal_keypad_debouncer
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    decimal_keypad_debouncer_if.slave   kp
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [NUM_KEYS-1:0] sync;

    state_e              state_d, state_q;
    logic [NUM_KEYS-1:0] pat_d, pat_q;
    logic [CNT_W-1:0]    cnt_d, cnt_q;
    logic [NUM_KEYS-1:0] decimal_out_d, decimal_out_q;
    logic                key_valid_d, key_valid_q;
    logic                key_held_d, key_held_q;
    logic                multi_err_d, multi_err_q;

    sync_2ff #(
        .WIDTH (NUM_KEYS)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (kp.key_raw),
        .q     (sync)
    );

    // Next state, candidate pattern, counter and output strobes.
    always_comb begin
        state_d       = state_q;
        pat_d         = pat_q;
        cnt_d         = cnt_q;
        decimal_out_d = decimal_out_q;
        key_valid_d   = 1'b0;
        multi_err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (sync != '0) begin
                    pat_d   = sync;
                    cnt_d   = CNT_ONE;
                    state_d = DB_PRESS;
                end
            end

            DB_PRESS: begin
                if (sync == '0) begin
                    // Released before it was stable: treat as a glitch.
                    state_d = IDLE;
                end else if (sync != pat_q) begin
                    // Pattern still moving: restart the stability window.
                    pat_d = sync;
                    cnt_d = CNT_ONE;
                end else if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    // Stable for the full window: accept or reject.
                    if (is_onehot(pat_q)) begin
                        decimal_out_d = pat_q;
                        key_valid_d   = 1'b1;
                    end else begin
                        multi_err_d   = 1'b1;
                    end
                    state_d = PRESSED;
                end
            end

            PRESSED: begin
                // Only an all-zero pattern starts release; other changes
                // (including roll-over) are ignored.
                if (sync == '0) begin
                    cnt_d   = CNT_ONE;
                    state_d = DB_REL;
                end
            end

            DB_REL: begin
                if (sync != '0) begin
                    state_d = PRESSED;
                end else if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered from the next state so it lines up with state_q.
        key_held_d = (state_d == PRESSED) || (state_d == DB_REL);
    end

    // State, pattern, counter and registered outputs; async clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pat_q         <= '0;
            cnt_q         <= '0;
            decimal_out_q <= '0;
            key_valid_q   <= 1'b0;
            key_held_q    <= 1'b0;
            multi_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pat_q         <= pat_d;
            cnt_q         <= cnt_d;
            decimal_out_q <= decimal_out_d;
            key_valid_q   <= key_valid_d;
            key_held_q    <= key_held_d;
            multi_err_q   <= multi_err_d;
        end
    end

    assign kp.decimal_out = decimal_out_q;
    assign kp.key_valid   = key_valid_q;
    assign kp.key_held    = key_held_q;
    assign kp.multi_err   = multi_err_q;
    assign kp.dbg_state   = state_q;

endmodule

// File: tb/tb_decimal_keypad_debouncer.sv
// Directed bench for decimal_keypad_debouncer with DEBOUNCE_CYCLES=4.
// Inputs change and outputs are sampled 1 time unit after a rising edge.
module tb_decimal_keypad_debouncer;
    import keypad_pkg::*;

    localparam int DC = 4;

    logic clk;
    logic rst_n;

    int n_cmp  = 0;
    int n_bad  = 0;
    int vld_n  = 0;
    int err_n  = 0;
    int both_n = 0;
    int v0;
    int e0;

    decimal_keypad_debouncer_if kp ();

    decimal_keypad_debouncer #(
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kp)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe counters, sampled on the falling edge.
    always @(negedge clk) begin
        if (kp.key_valid === 1'b1) vld_n++;
        if (kp.multi_err === 1'b1) err_n++;
        if ((kp.key_valid === 1'b1) && (kp.multi_err === 1'b1)) both_n++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // 1. Reset with all keys held
        rst_n = 1'b0;
        kp.key_raw = 10'h3FF;
        tick(3);
        chk("rst_dec",   32'(kp.decimal_out), 32'h0);
        chk("rst_vld",   32'(kp.key_valid),   32'h0);
        chk("rst_held",  32'(kp.key_held),    32'h0);
        chk("rst_err",   32'(kp.multi_err),   32'h0);
        chk("rst_state", 32'(kp.dbg_state),   32'(IDLE));
        rst_n = 1'b1;
        tick(DC + 1);
        chk("t1_err_e5", 32'(kp.multi_err), 32'h0);
        tick(1);
        chk("t1_err_e6", 32'(kp.multi_err), 32'h1);
        chk("t1_vld_e6", 32'(kp.key_valid), 32'h0);
        chk("t1_held",   32'(kp.key_held),  32'h1);
        tick(1);
        chk("t1_err_e7", 32'(kp.multi_err), 32'h0);
        kp.key_raw = '0;
        tick(DC + 1);
        chk("t1_held_r5", 32'(kp.key_held), 32'h1);
        tick(1);
        chk("t1_held_r6", 32'(kp.key_held),  32'h0);
        chk("t1_state",   32'(kp.dbg_state), 32'(IDLE));
        chk("t1_vld_n",   32'(vld_n),        32'd0);
        chk("t1_err_n",   32'(err_n),        32'd1);

        // 2. Clean press of key 7
        kp.key_raw = 10'b0010000000;
        tick(DC + 1);
        chk("t2_vld_e5", 32'(kp.key_valid), 32'h0);
        tick(1);
        chk("t2_vld_e6", 32'(kp.key_valid),   32'h1);
        chk("t2_dec",    32'(kp.decimal_out), 32'h080);
        chk("t2_held",   32'(kp.key_held),    32'h1);
        tick(1);
        chk("t2_vld_e7", 32'(kp.key_valid), 32'h0);
        tick(13);
        kp.key_raw = '0;
        tick(DC + 1);
        chk("t2_held_r5", 32'(kp.key_held), 32'h1);
        tick(1);
        chk("t2_held_r6", 32'(kp.key_held),    32'h0);
        chk("t2_dec_ret", 32'(kp.decimal_out), 32'h080);
        chk("t2_vld_n",   32'(vld_n),          32'd1);

        // 3. Key 3 bouncing, then stable
        v0 = vld_n;
        for (int i = 0; i < 3; i++) begin
            kp.key_raw = 10'b0000001000;
            tick(2);
            kp.key_raw = '0;
            tick(2);
        end
        chk("t3_no_vld", 32'(vld_n), 32'(v0));
        kp.key_raw = 10'b0000001000;
        tick(DC + 1);
        chk("t3_vld_e5", 32'(kp.key_valid), 32'h0);
        tick(1);
        chk("t3_vld_e6", 32'(kp.key_valid),   32'h1);
        chk("t3_dec",    32'(kp.decimal_out), 32'h008);
        tick(6);
        chk("t3_vld_n", 32'(vld_n), 32'(v0 + 1));
        kp.key_raw = '0;
        tick(DC + 2);
        chk("t3_held", 32'(kp.key_held), 32'h0);

        // 4. Keys 2 and 5 together
        v0 = vld_n;
        e0 = err_n;
        kp.key_raw = 10'b0000100100;
        tick(DC + 2);
        chk("t4_err",  32'(kp.multi_err),   32'h1);
        chk("t4_vld",  32'(kp.key_valid),   32'h0);
        chk("t4_dec",  32'(kp.decimal_out), 32'h008);
        chk("t4_held", 32'(kp.key_held),    32'h1);
        tick(1);
        chk("t4_err_e7", 32'(kp.multi_err), 32'h0);
        tick(4);
        kp.key_raw = '0;
        tick(DC + 1);
        chk("t4_held_r5", 32'(kp.key_held), 32'h1);
        tick(1);
        chk("t4_held_r6", 32'(kp.key_held), 32'h0);
        chk("t4_err_n",   32'(err_n),       32'(e0 + 1));
        chk("t4_vld_n",   32'(vld_n),       32'(v0));

        // 5. Glitch on key 0, then key 1 with roll-over to key 9
        v0 = vld_n;
        e0 = err_n;
        kp.key_raw = 10'b0000000001;
        tick(2);
        kp.key_raw = '0;
        tick(8);
        chk("t5_gl_vld",   32'(vld_n),        32'(v0));
        chk("t5_gl_err",   32'(err_n),        32'(e0));
        chk("t5_gl_state", 32'(kp.dbg_state), 32'(IDLE));
        chk("t5_gl_held",  32'(kp.key_held),  32'h0);
        kp.key_raw = 10'b0000000010;
        tick(DC + 2);
        chk("t5_vld", 32'(kp.key_valid),   32'h1);
        chk("t5_dec", 32'(kp.decimal_out), 32'h002);
        kp.key_raw = 10'b1000000010;
        tick(12);
        chk("t5_ro_vld_n", 32'(vld_n),          32'(v0 + 1));
        chk("t5_ro_dec",   32'(kp.decimal_out), 32'h002);
        chk("t5_ro_held",  32'(kp.key_held),    32'h1);
        kp.key_raw = 10'b1000000000;
        tick(10);
        chk("t5_k9_vld_n", 32'(vld_n),       32'(v0 + 1));
        chk("t5_k9_held",  32'(kp.key_held), 32'h1);
        kp.key_raw = '0;
        tick(DC + 2);
        chk("t5_rel_held", 32'(kp.key_held), 32'h0);

        // 6. Async reset in the middle of DB_PRESS
        kp.key_raw = 10'b0000010000;
        tick(4);
        chk("t6_pre_state", 32'(kp.dbg_state), 32'(DB_PRESS));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_dec",   32'(kp.decimal_out), 32'h0);
        chk("t6_rst_state", 32'(kp.dbg_state),   32'(IDLE));
        chk("t6_rst_held",  32'(kp.key_held),    32'h0);
        chk("t6_rst_vld",   32'(kp.key_valid),   32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(DC + 1);
        chk("t6_vld_e5", 32'(kp.key_valid), 32'h0);
        tick(1);
        chk("t6_vld_e6", 32'(kp.key_valid),   32'h1);
        chk("t6_dec",    32'(kp.decimal_out), 32'h010);
        kp.key_raw = '0;
        tick(DC + 2);
        chk("t6_held", 32'(kp.key_held), 32'h0);

        chk("never_both", 32'(both_n), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
